// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer argmax classifier.
//   - default widths / sizes used as module parameter defaults
//   - controller state encoding
//   - clog2 helper used to size address ports (never returns less than 1)
package nn_pkg;

    localparam int DEF_N_IN  = 784;
    localparam int DEF_N_OUT = 10;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_W_W   = 8;
    localparam int DEF_ACC_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        CMP,
        DONE
    } state_t;

    // Ceiling log2, clamped to 1 so a depth of 1 still yields a usable port.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int t = value - 1; t > 0; t = t >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nn_mac.sv
// Signed extend-multiply-accumulate unit.
//   clk, rst     : clock, synchronous active-high reset (clears o_acc)
//   i_load       : load i_load_val into the accumulator (bias preload)
//   i_load_val   : signed ACC_W preload value
//   i_en         : accumulate i_pix * i_wt this cycle
//   i_pix        : unsigned pixel, zero-extended before the multiply
//   i_wt         : signed weight
//   o_acc        : signed ACC_W accumulator, wraps modulo 2^ACC_W
module nn_mac
    import nn_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int W_W   = DEF_W_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic signed [ACC_W-1:0] i_load_val,
    input  logic                    i_en,
    input  logic [PIX_W-1:0]        i_pix,
    input  logic signed [W_W-1:0]   i_wt,
    output logic signed [ACC_W-1:0] o_acc
);

    localparam int PROD_W = PIX_W + 1 + W_W;

    logic signed [PIX_W:0]      w_pix_s;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    // Extra zero MSB makes the pixel a non-negative signed operand.
    assign w_pix_s    = {1'b0, i_pix};
    assign w_prod     = PROD_W'(w_pix_s) * PROD_W'(i_wt);
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/nn_dense_argmax.sv
// Dense layer (N_IN inputs x N_OUT neurons) followed by argmax.
//   clk, rst               : clock, synchronous active-high reset
//   start / done / busy    : level run request, result valid, computing
//   pix_we/addr/data       : pixel memory write port
//   w_we/addr/data         : weight memory write port, addr = neuron*N_IN + input
//   b_we/addr/data         : bias memory write port
//   predicted, max_score   : winning class and its score (held between runs)
//   wr_drop                : one-cycle pulse after an in-range write refused while busy
module nn_dense_argmax
    import nn_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int PIX_W = DEF_PIX_W,
    parameter int W_W   = DEF_W_W,
    parameter int ACC_W = DEF_ACC_W,
    localparam int AW_X = clog2(N_IN),
    localparam int AW_W = clog2(N_IN * N_OUT),
    localparam int IW   = clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    output logic             busy,
    input  logic             pix_we,
    input  logic [AW_X-1:0]  pix_addr,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             w_we,
    input  logic [AW_W-1:0]  w_addr,
    input  logic [W_W-1:0]   w_data,
    input  logic             b_we,
    input  logic [IW-1:0]    b_addr,
    input  logic [ACC_W-1:0] b_data,
    output logic [IW-1:0]    predicted,
    output logic [ACC_W-1:0] max_score,
    output logic             wr_drop
);

    logic [PIX_W-1:0]        r_mem_x [N_IN];
    logic signed [W_W-1:0]   r_mem_w [N_IN*N_OUT];
    logic signed [ACC_W-1:0] r_mem_b [N_OUT];

    state_t                  r_state, w_state_nx;
    logic [IW-1:0]           r_n;
    logic [AW_X-1:0]         r_i;
    logic                    r_mac_en;
    logic [PIX_W-1:0]        r_x_rd;
    logic signed [W_W-1:0]   r_w_rd;
    logic signed [ACC_W-1:0] r_b_rd;
    logic signed [ACC_W-1:0] r_best;
    logic [IW-1:0]           r_best_idx;
    logic [IW-1:0]           r_pred;
    logic signed [ACC_W-1:0] r_max;
    logic                    r_done;
    logic                    r_wr_drop;

    logic                    w_busy;
    logic                    w_i_last, w_n_last;
    logic                    w_pix_ok, w_w_ok, w_b_ok;
    logic [AW_W-1:0]         w_w_raddr;
    logic [IW-1:0]           w_b_raddr;
    logic signed [ACC_W-1:0] w_acc;
    logic                    w_take;
    logic signed [ACC_W-1:0] w_best_nx;
    logic [IW-1:0]           w_idx_nx;

    assign w_busy   = (r_state == BIAS) || (r_state == MAC) ||
                      (r_state == DRAIN) || (r_state == CMP);
    assign w_i_last = (32'(r_i) == N_IN - 1);
    assign w_n_last = (32'(r_n) == N_OUT - 1);

    assign w_pix_ok = 32'(pix_addr) < N_IN;
    assign w_w_ok   = 32'(w_addr) < N_IN * N_OUT;
    assign w_b_ok   = 32'(b_addr) < N_OUT;

    // ---- host write port: memories are only writable while idle/done
    always_ff @(posedge clk) begin
        if (pix_we && w_pix_ok && !w_busy) r_mem_x[pix_addr] <= pix_data;
        if (w_we && w_w_ok && !w_busy)     r_mem_w[w_addr]   <= w_data;
        if (b_we && w_b_ok && !w_busy)     r_mem_b[b_addr]   <= b_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_busy && ((pix_we && w_pix_ok) ||
                                    (w_we && w_w_ok) ||
                                    (b_we && w_b_ok));
        end
    end

    // Bias is prefetched one cycle ahead of BIAS: neuron 0 while idle,
    // neuron n+1 while comparing neuron n.
    assign w_w_raddr = AW_W'(32'(r_n) * N_IN + 32'(r_i));
    always_comb begin
        w_b_raddr = r_n;
        if (r_state == IDLE || r_state == DONE) begin
            w_b_raddr = '0;
        end else if (r_state == CMP) begin
            w_b_raddr = w_n_last ? '0 : r_n + IW'(1);
        end
    end

    // ---- stage p0 -> p1: synchronous memory reads
    always_ff @(posedge clk) begin
        r_x_rd <= r_mem_x[r_i];
        r_w_rd <= r_mem_w[w_w_raddr];
        r_b_rd <= r_mem_b[w_b_raddr];
    end

    // ---- stage p1 -> p2: multiply-accumulate of the read data
    nn_mac #(
        .PIX_W (PIX_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == BIAS),
        .i_load_val (r_b_rd),
        .i_en       (r_mac_en),
        .i_pix      (r_x_rd),
        .i_wt       (r_w_rd),
        .o_acc      (w_acc)
    );

    // Strict compare keeps the lowest index on ties.
    assign w_take    = (r_n == '0) || (w_acc > r_best);
    assign w_best_nx = w_take ? w_acc : r_best;
    assign w_idx_nx  = w_take ? r_n : r_best_idx;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nx = BIAS;
            BIAS:    w_state_nx = MAC;
            MAC:     if (w_i_last) w_state_nx = DRAIN;
            DRAIN:   w_state_nx = CMP;
            CMP:     w_state_nx = w_n_last ? DONE : BIAS;
            DONE:    if (!start) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n        <= '0;
            r_i        <= '0;
            r_mac_en   <= 1'b0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_pred     <= '0;
            r_max      <= '0;
            r_done     <= 1'b0;
        end else begin
            // Product of a MAC-cycle read arrives one cycle later.
            r_mac_en <= (r_state == MAC);
            case (r_state)
                IDLE: if (start) r_n <= '0;
                BIAS: r_i <= '0;
                MAC:  if (!w_i_last) r_i <= r_i + AW_X'(1);
                CMP: begin
                    r_best     <= w_best_nx;
                    r_best_idx <= w_idx_nx;
                    if (w_n_last) begin
                        r_pred <= w_idx_nx;
                        r_max  <= w_best_nx;
                        r_done <= 1'b1;
                    end else begin
                        r_n <= r_n + IW'(1);
                    end
                end
                DONE: if (!start) r_done <= 1'b0;
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign busy      = w_busy;
    assign predicted = r_pred;
    assign max_score = r_max;
    assign wr_drop   = r_wr_drop;

endmodule

// File: tb/tb_nn_dense_argmax.sv
module tb_nn_dense_argmax;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int LAT = NO * (NI + 3) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               done, busy;
    logic               pix_we;
    logic [1:0]         pix_addr;
    logic [7:0]         pix_data;
    logic               w_we;
    logic [3:0]         w_addr;
    logic [7:0]         w_data;
    logic               b_we;
    logic [1:0]         b_addr;
    logic [31:0]        b_data;
    logic [1:0]         predicted;
    logic signed [31:0] max_score;
    logic               wr_drop;

    int checks = 0;
    int errors = 0;

    // Bench-side record of memory contents and pending load values.
    int m_x[NI];
    int m_w[NI*NO];
    int m_b[NO];
    int tx[NI];
    int tw[NI*NO];
    int tb[NO];

    always #5 clk = ~clk;

    nn_dense_argmax #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .predicted(predicted), .max_score(max_score), .wr_drop(wr_drop)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: score[n] = bias[n] + sum(x[i]*w[n][i]) mod 2^32, first max wins.
    function automatic void model(output int p, output int s);
        int sc[NO];
        for (int n = 0; n < NO; n++) begin
            longint a;
            a = longint'(m_b[n]);
            for (int i = 0; i < NI; i++) a += longint'(m_x[i]) * longint'(m_w[n*NI+i]);
            sc[n] = int'(a);
        end
        p = 0;
        s = sc[0];
        for (int n = 1; n < NO; n++) if (sc[n] > s) begin s = sc[n]; p = n; end
    endfunction

    task automatic load_all();
        for (int k = 0; k < NI*NO; k++) begin
            pix_we = (k < NI); pix_addr = 2'(k % NI); pix_data = 8'(tx[k % NI]);
            w_we = 1'b1;       w_addr = 4'(k);        w_data = 8'(tw[k]);
            b_we = (k < NO);   b_addr = 2'(k % NO);   b_data = 32'(tb[k % NO]);
            @(posedge clk); #1;
        end
        pix_we = 1'b0; w_we = 1'b0; b_we = 1'b0;
        m_x = tx; m_w = tw; m_b = tb;
        check("load_no_drop", wr_drop, 0);
    endtask

    task automatic run(input string tag, input int drop_at, input bit toggle,
                       input bit pre_wr);
        int cnt, ep, es;
        bit seen;
        if (pre_wr) begin
            pix_we = 1'b1; pix_addr = 2'd3; pix_data = 8'd10;
            m_x[3] = 10;
        end
        model(ep, es);
        start = 1'b1;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                pix_we = 1'b0;
                check({tag, ".busy"}, busy, 1);
            end
            if (toggle) begin
                if (cnt == 3) start = 1'b0;
                if (cnt == 8) start = 1'b1;
            end
            if (drop_at > 0) begin
                if (cnt == drop_at) begin
                    pix_we = 1'b1; pix_addr = 2'd0; pix_data = 8'd99;
                end
                if (cnt == drop_at + 1) begin
                    check({tag, ".drop"}, wr_drop, 1);
                    pix_we = 1'b0;
                    w_we = 1'b1; w_addr = 4'd13; w_data = 8'd5;
                end
                if (cnt == drop_at + 2) begin
                    check({tag, ".drop_once"}, wr_drop, 0);
                    w_we = 1'b0;
                end
            end
            if (done) seen = 1'b1;
        end
        check({tag, ".latency"}, cnt, LAT);
        check({tag, ".pred"}, predicted, ep);
        check({tag, ".score"}, max_score, es);
        check({tag, ".busy_done"}, busy, 0);
    endtask

    task automatic end_run(input string tag);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".done_clr"}, done, 0);
        @(posedge clk); #1;
    endtask

    task automatic set_base();
        tx = '{1, 2, 3, 4};
        for (int k = 0; k < NI*NO; k++) tw[k] = 1;
        tb = '{0, 5, -2};
    endtask

    initial begin
        int ep, es;
        bit saw;
        rst = 1'b1; start = 1'b0;
        pix_we = 1'b0; pix_addr = '0; pix_data = '0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        b_we = 1'b0; b_addr = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.done", done, 0);
        check("rst.busy", busy, 0);
        check("rst.pred", predicted, 0);
        check("rst.score", max_score, 0);
        check("rst.drop", wr_drop, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic example, explicit expected values.
        set_base();
        load_all();
        model(ep, es);
        check("base.model_pred", ep, 1);
        check("base.model_score", es, 15);
        run("base", 0, 1'b0, 1'b0);
        check("base.pred_const", predicted, 1);
        check("base.score_const", max_score, 15);

        // start held after done: done stays high, result held.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("hold.done", done, 1);
        end
        check("hold.pred", predicted, 1);
        end_run("hold");
        run("rerun", 0, 1'b0, 1'b0);
        end_run("rerun");

        // Write while busy is dropped; start toggling mid-run ignored.
        run("drop", 5, 1'b1, 1'b0);
        check("drop.score_const", max_score, 15);
        end_run("drop");

        // Out-of-range bias write while idle: no pulse, no effect.
        b_we = 1'b1; b_addr = 2'd3; b_data = 32'd1000;
        @(posedge clk); #1;
        b_we = 1'b0;
        check("oor.nodrop", wr_drop, 0);
        run("oor", 0, 1'b0, 1'b0);
        end_run("oor");

        // Reset five cycles into a run.
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check("abort.done", done, 0);
        check("abort.busy", busy, 0);
        check("abort.pred", predicted, 0);
        check("abort.score", max_score, 0);
        saw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        check("abort.idle", saw, 0);
        run("after_abort", 0, 1'b0, 1'b0);
        check("after_abort.score_const", max_score, 15);
        end_run("after_abort");

        // Pixel write in the start-sampling cycle is used by the run.
        run("same_cycle", 0, 1'b0, 1'b1);
        check("same_cycle.score_const", max_score, 21);
        end_run("same_cycle");

        // Tie: lowest index wins.
        for (int k = 0; k < NI*NO; k++) tw[k] = 0;
        tb = '{7, 7, 7};
        load_all();
        run("tie", 0, 1'b0, 1'b0);
        check("tie.pred_const", predicted, 0);
        check("tie.score_const", max_score, 7);
        end_run("tie");

        // Negative products: neuron 0 = 4*255*-128.
        tx = '{255, 255, 255, 255};
        for (int k = 0; k < NI*NO; k++) tw[k] = (k < NI) ? -128 : 0;
        tb = '{0, 0, 0};
        load_all();
        run("neg", 0, 1'b0, 1'b0);
        check("neg.pred_const", predicted, 1);
        check("neg.score_const", max_score, 0);
        end_run("neg");
        tb = '{0, -200000, -200000};
        load_all();
        run("neg0", 0, 1'b0, 1'b0);
        check("neg0.pred_const", predicted, 0);
        check("neg0.score_const", max_score, -130560);
        end_run("neg0");

        // Random contents, including wrapping biases.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NI; i++) tx[i] = int'($urandom_range(0, 255));
            for (int k = 0; k < NI*NO; k++) tw[k] = int'($urandom_range(0, 255)) - 128;
            for (int n = 0; n < NO; n++) tb[n] = (r < 4) ? int'($urandom_range(0, 2000)) - 1000
                                                          : int'($urandom());
            load_all();
            run("rand", (r % 2 == 0) ? 4 + r : 0, r[0], 1'b0);
            end_run("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_dense_argmax.md
NN_DENSE_ARGMAX -- requirements
Module: nn_dense_argmax

Interface
REQ-001 SHALL have parameter N_IN, default 784, number of input pixels.
REQ-002 SHALL have parameter N_OUT, default 10, number of output neurons/classes.
REQ-003 SHALL have parameter PIX_W, default 8, unsigned pixel width.
REQ-004 SHALL have parameter W_W, default 8, signed weight width.
REQ-005 SHALL have parameter ACC_W, default 32, signed accumulator/bias/score width.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset (synchronous, active-high).
REQ-007 SHALL have ports: start in 1 run request (level); done out 1 result valid; busy out 1 computing.
REQ-008 SHALL have ports: pix_we in 1; pix_addr in AW_X=clog2(N_IN); pix_data in PIX_W; pixel write.
REQ-009 SHALL have ports: w_we in 1; w_addr in AW_W=clog2(N_IN*N_OUT); w_data in W_W; weight write, addr = neuron*N_IN + input.
REQ-010 SHALL have ports: b_we in 1; b_addr in IW=clog2(N_OUT); b_data in ACC_W; bias write.
REQ-011 SHALL have ports: predicted out IW argmax class; max_score out ACC_W winning score; wr_drop out 1 one-cycle pulse on rejected write.

Function
REQ-012 SHALL use states IDLE, BIAS, MAC, DRAIN, CMP, DONE.
REQ-013 IDLE: busy=0, done=0; start=1 -> BIAS with neuron index n=0.
REQ-014 BIAS: acc <= bias[n], input index i <= 0, 1 cycle -> MAC.
REQ-015 MAC: one synchronous read of x[i] and w[n*N_IN+i] per cycle (1-cycle read latency), N_IN cycles -> DRAIN.
REQ-016 DRAIN: 1 cycle, final product accumulated; then CMP.
REQ-017 Arithmetic: product = zero-extended pixel x signed weight, sign-extended to ACC_W; acc wraps modulo 2^ACC_W (no saturation).
REQ-018 CMP: if n==0 or acc > best (signed, strict), best<=acc, best_idx<=n; ties keep lowest index; if n==N_OUT-1 -> DONE else n<=n+1 -> BIAS.
REQ-019 Latency: done SHALL rise exactly N_OUT*(N_IN+3)+1 cycles after the cycle start is sampled high in IDLE.
REQ-020 On entering DONE: predicted<=best_idx, max_score<=best, done<=1 in the same cycle.
REQ-021 DONE: done held while start=1; start=0 -> done<=0, IDLE next cycle.
REQ-022 predicted/max_score SHALL hold last result until next DONE entry.
REQ-023 busy=1 in BIAS, MAC, DRAIN, CMP; 0 in IDLE, DONE.
REQ-024 Writes accepted only when busy=0; write with busy=1 SHALL be ignored and pulse wr_drop next cycle.
REQ-025 Out-of-range address (>= depth) SHALL be ignored without wr_drop.
REQ-026 Simultaneous pix_we, w_we, b_we SHALL all be accepted (separate memories).
REQ-027 Write to x/w in the same cycle start is sampled in IDLE SHALL be accepted and visible to the run.
REQ-028 start toggles while busy SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE; done=0, busy=0, predicted=0, max_score=0, wr_drop=0, acc/best/indices=0.
REQ-030 rst mid-run SHALL abort immediately; no done produced; memory contents retained (not cleared).
REQ-031 After rst release, new run requires start sampled high in IDLE.

Structure
REQ-032 Shared package nn_pkg SHALL hold state enum, clog2 function, default widths.
REQ-033 One sub-module nn_mac SHALL implement signed extend-multiply-accumulate with load (bias) and enable inputs.
REQ-034 Memories SHALL be inferable as synchronous single-read RAMs (no reset on contents).

Verification
REQ-035 N_IN=4, N_OUT=3, x={1,2,3,4}, all w=1, bias={0,5,-2}: done at cycle 22 after start; predicted=1, max_score=15.
REQ-036 Tie: all w=0, bias={7,7,7}: predicted=0, max_score=7.
REQ-037 Negative: x={255,255,255,255}, w neuron0=-128 all, others 0, bias 0: max_score=0, predicted=1; neuron0 acc=-130560 checked internally.
REQ-038 pix_we during MAC to addr 0 with data 99: wr_drop pulses once, result identical to REQ-035.
REQ-039 rst asserted 5 cycles into run: outputs zero next cycle, no done; rerun start -> REQ-035 result.
REQ-040 Hold start high after done for 10 cycles: done stays 1; drop start: done=0 next cycle, second run repeats result.
